// File: rtl/ccu_wb_unit_if.sv
// Bus bundle for the write-back engine: command, snoop data (CD), AXI AW/W/B and completion.
// Signal suffixes are as seen from the write-back unit, which uses the master modport.
interface ccu_wb_unit_if #(
    parameter int unsigned AddrWidth = 64,
    parameter int unsigned DataWidth = 64,
    parameter int unsigned IdWidth   = 4
);
    logic                   cmd_valid_i;
    logic                   cmd_ready_o;
    logic [AddrWidth-1:0]   cmd_addr_i;
    logic [IdWidth-1:0]     cmd_id_i;
    logic [7:0]             cmd_len_i;
    logic [2:0]             cmd_size_i;

    logic                   cd_valid_i;
    logic                   cd_ready_o;
    logic [DataWidth-1:0]   cd_data_i;
    logic                   cd_last_i;

    logic                   aw_valid_o;
    logic                   aw_ready_i;
    logic [AddrWidth-1:0]   aw_addr_o;
    logic [IdWidth-1:0]     aw_id_o;
    logic [7:0]             aw_len_o;
    logic [2:0]             aw_size_o;
    logic [1:0]             aw_burst_o;

    logic                   w_valid_o;
    logic                   w_ready_i;
    logic [DataWidth-1:0]   w_data_o;
    logic [DataWidth/8-1:0] w_strb_o;
    logic                   w_last_o;

    logic                   b_valid_i;
    logic                   b_ready_o;
    logic [IdWidth-1:0]     b_id_i;
    logic [1:0]             b_resp_i;

    logic                   done_valid_o;
    logic                   done_ready_i;
    logic [1:0]             done_resp_o;

    modport master (
        input  cmd_valid_i, cmd_addr_i, cmd_id_i, cmd_len_i, cmd_size_i,
        input  cd_valid_i, cd_data_i, cd_last_i,
        input  aw_ready_i, w_ready_i,
        input  b_valid_i, b_id_i, b_resp_i,
        input  done_ready_i,
        output cmd_ready_o, cd_ready_o,
        output aw_valid_o, aw_addr_o, aw_id_o, aw_len_o, aw_size_o, aw_burst_o,
        output w_valid_o, w_data_o, w_strb_o, w_last_o,
        output b_ready_o,
        output done_valid_o, done_resp_o
    );

    modport slave (
        output cmd_valid_i, cmd_addr_i, cmd_id_i, cmd_len_i, cmd_size_i,
        output cd_valid_i, cd_data_i, cd_last_i,
        output aw_ready_i, w_ready_i,
        output b_valid_i, b_id_i, b_resp_i,
        output done_ready_i,
        input  cmd_ready_o, cd_ready_o,
        input  aw_valid_o, aw_addr_o, aw_id_o, aw_len_o, aw_size_o, aw_burst_o,
        input  w_valid_o, w_data_o, w_strb_o, w_last_o,
        input  b_ready_o,
        input  done_valid_o, done_resp_o
    );
endinterface

// File: rtl/ccu_wb_unit.sv
// Write-back engine: one command plus a CD beat stream becomes a single AXI INCR write burst
// (AW, W beats, B), completed with a merged response on the done channel.
module ccu_wb_unit #(
    parameter int unsigned AddrWidth = 64,
    parameter int unsigned DataWidth = 64,
    parameter int unsigned IdWidth   = 4
) (
    input  logic          clk_i,
    input  logic          rst_ni,
    ccu_wb_unit_if.master bus
);

    typedef enum logic [2:0] {IDLE, AW, W, B, DONE} state_e;

    localparam logic [1:0] RespSlvErr = 2'b10;

    state_e               state_q, state_d;
    logic [AddrWidth-1:0] addr_q;
    logic [IdWidth-1:0]   id_q;
    logic [7:0]           len_q;
    logic [2:0]           size_q;
    logic [7:0]           cnt_q;
    logic                 err_q;
    logic [1:0]           resp_q;

    logic cmd_ready, aw_valid, w_valid, cd_ready, b_ready, done_valid;
    logic last_beat, cmd_hs, w_hs, b_hs;

    assign last_beat = (cnt_q == len_q);
    assign cmd_hs    = cmd_ready & bus.cmd_valid_i;
    assign w_hs      = w_valid & bus.w_ready_i;
    assign b_hs      = b_ready & bus.b_valid_i;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (bus.cmd_valid_i)              state_d = AW;
            AW:      if (bus.aw_ready_i)               state_d = W;
            W:       if (w_hs && last_beat)            state_d = B;
            B:       if (bus.b_valid_i)                state_d = DONE;
            DONE:    if (bus.done_ready_i)             state_d = IDLE;
            default:                                   state_d = IDLE;
        endcase
    end

    // W is a combinational pass-through of CD, gated only by the state.
    always_comb begin
        cmd_ready  = 1'b0;
        aw_valid   = 1'b0;
        w_valid    = 1'b0;
        cd_ready   = 1'b0;
        b_ready    = 1'b0;
        done_valid = 1'b0;
        case (state_q)
            IDLE: cmd_ready = 1'b1;
            AW:   aw_valid  = 1'b1;
            W: begin
                w_valid  = bus.cd_valid_i;
                cd_ready = bus.w_ready_i;
            end
            B:    b_ready    = 1'b1;
            DONE: done_valid = 1'b1;
            default: ;
        endcase
    end

    // Burst length comes from the command; cd_last_i only feeds the framing check.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            addr_q <= '0;
            id_q   <= '0;
            len_q  <= '0;
            size_q <= '0;
            cnt_q  <= '0;
            err_q  <= 1'b0;
            resp_q <= '0;
        end else begin
            if (cmd_hs) begin
                addr_q <= bus.cmd_addr_i;
                id_q   <= bus.cmd_id_i;
                len_q  <= bus.cmd_len_i;
                size_q <= bus.cmd_size_i;
                cnt_q  <= '0;
                err_q  <= 1'b0;
            end
            if (w_hs) begin
                if (!last_beat) cnt_q <= cnt_q + 8'd1;
                if (bus.cd_last_i != last_beat) err_q <= 1'b1;
            end
            if (b_hs) begin
                if (bus.b_id_i != id_q) err_q <= 1'b1;
                resp_q <= (err_q || (bus.b_id_i != id_q)) ? RespSlvErr : bus.b_resp_i;
            end
        end
    end

    assign bus.cmd_ready_o  = cmd_ready;
    assign bus.cd_ready_o   = cd_ready;
    assign bus.aw_valid_o   = aw_valid;
    assign bus.aw_addr_o    = addr_q;
    assign bus.aw_id_o      = id_q;
    assign bus.aw_len_o     = len_q;
    assign bus.aw_size_o    = size_q;
    assign bus.aw_burst_o   = 2'b01;
    assign bus.w_valid_o    = w_valid;
    assign bus.w_data_o     = bus.cd_data_i;
    assign bus.w_strb_o     = {(DataWidth/8){1'b1}};
    assign bus.w_last_o     = (state_q == W) && last_beat;
    assign bus.b_ready_o    = b_ready;
    assign bus.done_valid_o = done_valid;
    assign bus.done_resp_o  = resp_q;

endmodule

// File: tb/tb_ccu_wb_unit.sv
// Directed bench for ccu_wb_unit: scoreboarded W beats and completion responses,
// including stalls, framing/B errors, back-to-back commands and mid-burst reset.
module tb_ccu_wb_unit;
    localparam int unsigned AddrWidth = 64;
    localparam int unsigned DataWidth = 64;
    localparam int unsigned IdWidth   = 4;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    int          checks = 0;
    int          errors = 0;
    int unsigned cyc = 0;

    logic [DataWidth-1:0] exp_data_q[$];
    logic                 exp_last_q[$];
    logic [1:0]           exp_resp_q[$];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    ccu_wb_unit_if #(.AddrWidth(AddrWidth), .DataWidth(DataWidth), .IdWidth(IdWidth)) bus();

    ccu_wb_unit #(.AddrWidth(AddrWidth), .DataWidth(DataWidth), .IdWidth(IdWidth)) dut (
        .clk_i (clk),
        .rst_ni(rst_n),
        .bus   (bus)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic idle_inputs();
        bus.cmd_valid_i  = 1'b0;
        bus.cmd_addr_i   = '0;
        bus.cmd_id_i     = '0;
        bus.cmd_len_i    = '0;
        bus.cmd_size_i   = '0;
        bus.cd_valid_i   = 1'b0;
        bus.cd_data_i    = '0;
        bus.cd_last_i    = 1'b0;
        bus.aw_ready_i   = 1'b0;
        bus.w_ready_i    = 1'b0;
        bus.b_valid_i    = 1'b0;
        bus.b_id_i       = '0;
        bus.b_resp_i     = '0;
        bus.done_ready_i = 1'b0;
    endtask

    task automatic chk_quiet(input string tag);
        chk({tag, "_aw_valid"}, 64'(bus.aw_valid_o), 64'(0));
        chk({tag, "_w_valid"}, 64'(bus.w_valid_o), 64'(0));
        chk({tag, "_cd_ready"}, 64'(bus.cd_ready_o), 64'(0));
        chk({tag, "_b_ready"}, 64'(bus.b_ready_o), 64'(0));
        chk({tag, "_done_valid"}, 64'(bus.done_valid_o), 64'(0));
        chk({tag, "_cmd_ready"}, 64'(bus.cmd_ready_o), 64'(1));
    endtask

    // Entered and left at #1 after a rising edge.
    task automatic run_burst(input logic [63:0] addr, input logic [3:0] id, input int len,
                             input logic [2:0] size, input int bad_last, input logic [1:0] bresp,
                             input logic [3:0] bid, input bit stall, input int abort_after,
                             input bit b2b, input bit chk_lat);
        logic [DataWidth-1:0] beats[$];
        logic [1:0]           r;
        int                   k;
        int                   guard;
        int unsigned          c0;
        bit                   hs;

        for (int i = 0; i <= len; i++) begin
            logic [63:0] d;
            d = {$urandom, $urandom};
            beats.push_back(d);
            exp_data_q.push_back(d);
            exp_last_q.push_back(i == len);
        end
        exp_resp_q.push_back((bad_last >= 0 || bid != id) ? 2'b10 : bresp);

        bus.cmd_valid_i  = 1'b1;
        bus.cmd_addr_i   = addr;
        bus.cmd_id_i     = id;
        bus.cmd_len_i    = len[7:0];
        bus.cmd_size_i   = size;
        bus.done_ready_i = b2b;
        @(negedge clk);
        chk("cmd_ready_idle", 64'(bus.cmd_ready_o), 64'(1));
        c0 = cyc;
        @(posedge clk); #1;
        if (!b2b) bus.cmd_valid_i = 1'b0;

        // CD offered during AW must not leak onto W
        bus.cd_valid_i = 1'b1;
        bus.cd_data_i  = beats[0];
        bus.w_ready_i  = 1'b1;
        hs = 1'b0;
        guard = 0;
        while (!hs) begin
            bus.aw_ready_i = stall ? 1'($urandom_range(0, 1)) : 1'b1;
            @(negedge clk);
            chk("aw_valid", 64'(bus.aw_valid_o), 64'(1));
            chk("aw_addr", 64'(bus.aw_addr_o), addr);
            chk("aw_id", 64'(bus.aw_id_o), 64'(id));
            chk("aw_len", 64'(bus.aw_len_o), 64'(len[7:0]));
            chk("aw_size", 64'(bus.aw_size_o), 64'(size));
            chk("aw_burst", 64'(bus.aw_burst_o), 64'(2'b01));
            chk("w_valid_in_aw", 64'(bus.w_valid_o), 64'(0));
            chk("cd_ready_in_aw", 64'(bus.cd_ready_o), 64'(0));
            chk("cmd_ready_busy", 64'(bus.cmd_ready_o), 64'(0));
            hs = bus.aw_ready_i;
            guard++;
            if (!hs && guard > 100) begin
                chk("aw_timeout", 64'(0), 64'(1));
                hs = 1'b1;
            end
            @(posedge clk); #1;
        end
        bus.aw_ready_i = 1'b0;

        k = 0;
        guard = 0;
        while (k <= len) begin
            if (k == abort_after) begin
                rst_n = 1'b0;
                #1;
                chk_quiet("abort");
                chk("abort_aw_addr", 64'(bus.aw_addr_o), 64'(0));
                chk("abort_done_resp", 64'(bus.done_resp_o), 64'(0));
                exp_data_q.delete();
                exp_last_q.delete();
                exp_resp_q.delete();
                idle_inputs();
                return;
            end
            bus.cd_valid_i = stall ? 1'($urandom_range(0, 1)) : 1'b1;
            bus.cd_data_i  = beats[k];
            bus.cd_last_i  = (k == len) ^ (k == bad_last);
            bus.w_ready_i  = stall ? 1'($urandom_range(0, 1)) : 1'b1;
            @(negedge clk);
            chk("w_valid", 64'(bus.w_valid_o), 64'(bus.cd_valid_i));
            chk("cd_ready", 64'(bus.cd_ready_o), 64'(bus.w_ready_i));
            chk("w_last_pos", 64'(bus.w_last_o), 64'(k == len));
            chk("w_strb", 64'(bus.w_strb_o), 64'(8'hff));
            chk("b_ready_in_w", 64'(bus.b_ready_o), 64'(0));
            if (bus.cd_valid_i && bus.w_ready_i) begin
                chk("w_data", 64'(bus.w_data_o), 64'(exp_data_q.pop_front()));
                chk("w_last", 64'(bus.w_last_o), 64'(exp_last_q.pop_front()));
                k++;
            end
            guard++;
            if (k <= len && guard > 3000) begin
                chk("w_timeout", 64'(0), 64'(1));
                k = len + 1;
            end
            @(posedge clk); #1;
        end
        bus.cd_valid_i = 1'b0;
        bus.cd_last_i  = 1'b0;
        bus.w_ready_i  = 1'b0;

        if (stall) begin
            repeat ($urandom_range(1, 3)) begin
                @(negedge clk);
                chk("b_ready_wait", 64'(bus.b_ready_o), 64'(1));
                chk("done_valid_early", 64'(bus.done_valid_o), 64'(0));
                @(posedge clk); #1;
            end
        end
        bus.b_valid_i = 1'b1;
        bus.b_id_i    = bid;
        bus.b_resp_i  = bresp;
        @(negedge clk);
        chk("b_ready", 64'(bus.b_ready_o), 64'(1));
        chk("w_valid_in_b", 64'(bus.w_valid_o), 64'(0));
        @(posedge clk); #1;
        bus.b_valid_i = 1'b0;
        bus.b_resp_i  = 2'b00;

        r = exp_resp_q.pop_front();
        if (stall) begin
            bus.done_ready_i = 1'b0;
            repeat ($urandom_range(1, 3)) begin
                @(negedge clk);
                chk("done_valid_hold", 64'(bus.done_valid_o), 64'(1));
                chk("done_resp_hold", 64'(bus.done_resp_o), 64'(r));
                @(posedge clk); #1;
            end
        end
        bus.done_ready_i = 1'b1;
        @(negedge clk);
        chk("done_valid", 64'(bus.done_valid_o), 64'(1));
        chk("done_resp", 64'(bus.done_resp_o), 64'(r));
        chk("cmd_ready_in_done", 64'(bus.cmd_ready_o), 64'(0));
        if (chk_lat) chk("done_latency", 64'(cyc - c0), 64'(4 + len));
        @(posedge clk); #1;
        if (!b2b) begin
            bus.done_ready_i = 1'b0;
            bus.cmd_valid_i  = 1'b0;
            @(negedge clk);
            chk("idle_cmd_ready", 64'(bus.cmd_ready_o), 64'(1));
            chk("idle_done_valid", 64'(bus.done_valid_o), 64'(0));
            chk("idle_aw_valid", 64'(bus.aw_valid_o), 64'(0));
            @(posedge clk); #1;
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog expired");
        $fatal(1, "bench watchdog");
    end

    initial begin
        idle_inputs();
        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk_quiet("reset");
        chk("reset_aw_addr", 64'(bus.aw_addr_o), 64'(0));
        chk("reset_aw_id", 64'(bus.aw_id_o), 64'(0));
        chk("reset_aw_len", 64'(bus.aw_len_o), 64'(0));
        chk("reset_aw_size", 64'(bus.aw_size_o), 64'(0));
        chk("reset_done_resp", 64'(bus.done_resp_o), 64'(0));
        rst_n = 1'b1;
        @(posedge clk); #1;

        // addr, id, len, size, bad_last, bresp, bid, stall, abort_after, b2b, chk_lat
        run_burst(64'h1000, 4'd3, 0, 3'd3, -1, 2'b00, 4'd3, 1'b0, -1, 1'b0, 1'b1);
        run_burst(64'h2040, 4'd5, 3, 3'd3, -1, 2'b00, 4'd5, 1'b1, -1, 1'b0, 1'b0);
        run_burst(64'h3000, 4'd1, 3, 3'd3,  1, 2'b00, 4'd1, 1'b0, -1, 1'b0, 1'b1);
        run_burst(64'h4100, 4'd9, 1, 3'd2, -1, 2'b11, 4'd9, 1'b1, -1, 1'b0, 1'b0);
        run_burst(64'h5200, 4'd7, 2, 3'd3, -1, 2'b00, 4'd2, 1'b0, -1, 1'b0, 1'b1);
        run_burst(64'h6000, 4'd4, 1, 3'd3, -1, 2'b01, 4'd4, 1'b0, -1, 1'b1, 1'b1);
        run_burst(64'h6800, 4'd6, 2, 3'd3, -1, 2'b00, 4'd6, 1'b0, -1, 1'b0, 1'b1);
        run_burst(64'h7000, 4'd2, 255, 3'd3, -1, 2'b00, 4'd2, 1'b0, -1, 1'b0, 1'b1);
        run_burst(64'h8000, 4'd8, 7, 3'd3, -1, 2'b00, 4'd8, 1'b0, 2, 1'b0, 1'b0);
        @(negedge clk);
        chk_quiet("in_reset");
        rst_n = 1'b1;
        @(posedge clk); #1;
        run_burst(64'h9000, 4'd10, 7, 3'd3, -1, 2'b00, 4'd10, 1'b0, -1, 1'b0, 1'b1);

        chk("scoreboard_empty", 64'(exp_data_q.size() + exp_resp_q.size()), 64'(0));
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
